// File: rtl/irq_request_latch.sv
// irq_request_latch: request-capture front end for an 8-source interrupt
// controller. It synchronises the raw request lines, detects edge or level
// events, holds them as sticky pending bits and drives the 8-to-3 priority
// encoder input.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_in     raw asynchronous request lines (bit 7 = highest priority)
//   mode       per-line trigger mode: 1 = rising edge, 0 = level
//   mask       per-line enable: 1 = enabled
//   ack_valid  one-cycle acknowledge strobe
//   ack_idx    index of the line being acknowledged
//   pend_o     pend & mask, to the priority encoder
//   any_pend   OR of pend_o; qualifies the encoder output
//   ovf_o      sticky per-line overflow (only with IRQ_OVF_EN)
//
// Build option: define IRQ_OVF_EN to add the ovf_o port and overflow logic.
module irq_request_latch #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mode,
  input  logic [N_REQ-1:0] mask,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  output logic [N_REQ-1:0] pend_o,
  output logic             any_pend
`ifdef IRQ_OVF_EN
  ,
  output logic [N_REQ-1:0] ovf_o
`endif
);

  logic [N_REQ-1:0] s1_q, s1_d;
  logic [N_REQ-1:0] s2_q, s2_d;
  logic [N_REQ-1:0] req_d_q, req_d_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] edge_evt;
  logic [N_REQ-1:0] evt_set;
  logic [N_REQ-1:0] ack_clr;
`ifdef IRQ_OVF_EN
  logic [N_REQ-1:0] ovf_q, ovf_d;
  logic [N_REQ-1:0] ovf_set;
`endif

  // Synchroniser, event detection and pending-bit update
  always_comb begin
    s1_d     = req_in;
    s2_d     = s1_q;
    req_d_d  = s2_q;
    edge_evt = s2_q & ~req_d_q;
    // Edge lines fire on a synchronised rising edge, level lines while high
    evt_set  = ((mode & edge_evt) | (~mode & s2_q)) & mask;
    ack_clr  = '0;
    if (ack_valid) begin
      ack_clr[ack_idx] = 1'b1;
    end
    // Set applied after clear, so a coincident set wins
    pend_d   = (pend_q & ~ack_clr) | evt_set;
  end

`ifdef IRQ_OVF_EN
  // Overflow: a new edge event on a line whose pending bit is still
  // outstanding and not being acknowledged this cycle
  always_comb begin
    ovf_set = mode & edge_evt & mask & pend_q & ~ack_clr;
    ovf_d   = (ovf_q & ~ack_clr) | ovf_set;
  end
`endif

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      req_d_q <= '0;
      pend_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      req_d_q <= req_d_d;
      pend_q  <= pend_d;
    end
  end

`ifdef IRQ_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

  // Masking only gates the view; the pend register itself is untouched
  assign pend_o   = pend_q & mask;
  assign any_pend = |pend_o;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed self-checking bench for irq_request_latch.
module tb_irq_request_latch;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mode;
  logic [7:0] mask;
  logic       ack_valid;
  logic [2:0] ack_idx;
  logic [7:0] pend_o;
  logic       any_pend;
`ifdef IRQ_OVF_EN
  logic [7:0] ovf_o;
`endif

  int total;
  int bad;

  irq_request_latch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mode      (mode),
    .mask      (mask),
    .ack_valid (ack_valid),
    .ack_idx   (ack_idx),
    .pend_o    (pend_o),
    .any_pend  (any_pend)
`ifdef IRQ_OVF_EN
    ,
    .ovf_o     (ovf_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ack(input logic [2:0] idx);
    ack_valid = 1'b1;
    ack_idx   = idx;
    @(negedge clk);
    ack_valid = 1'b0;
    ack_idx   = 3'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = 8'h00; mode = 8'hFF; mask = 8'hFF;
    ack_valid = 1'b0; ack_idx = 3'd0;
    #1;
    total++;
    if (pend_o !== 8'h00 || any_pend !== 1'b0) begin
      bad++; $display("FAIL reset_hold pend_o=%h any=%b exp 00/0", pend_o, any_pend);
    end
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      total++;
      if (pend_o !== 8'h00 || any_pend !== 1'b0) begin
        bad++; $display("FAIL reset_release c%0d pend_o=%h any=%b exp 00/0", i, pend_o, any_pend);
      end
    end
  endtask

  task automatic test_edge_capture();
    mode = 8'hFF; mask = 8'hFF;
    req_in = 8'h20;             // high for one cycle before edge k
    cyc(1);
    req_in = 8'h00;
    total++;
    if (pend_o !== 8'h00) begin
      bad++; $display("FAIL edge_lat_k pend_o=%h exp 00", pend_o);
    end
    cyc(1);
    total++;
    if (pend_o !== 8'h00) begin
      bad++; $display("FAIL edge_lat_k1 pend_o=%h exp 00", pend_o);
    end
    cyc(1);
    total++;
    if (pend_o !== 8'h20 || any_pend !== 1'b1) begin
      bad++; $display("FAIL edge_lat_k2 pend_o=%h any=%b exp 20/1", pend_o, any_pend);
    end
    cyc(3);
    total++;
    if (pend_o !== 8'h20) begin
      bad++; $display("FAIL edge_sticky pend_o=%h exp 20", pend_o);
    end
    do_ack(3'd3);               // ack of a clear bit: no effect
    total++;
    if (pend_o !== 8'h20) begin
      bad++; $display("FAIL ack_idle_bit pend_o=%h exp 20", pend_o);
    end
    do_ack(3'd5);
    total++;
    if (pend_o !== 8'h00 || any_pend !== 1'b0) begin
      bad++; $display("FAIL edge_ack pend_o=%h any=%b exp 00/0", pend_o, any_pend);
    end
  endtask

  task automatic test_level_set_wins();
    mode = 8'h00; mask = 8'hFF;
    req_in = 8'h81;
    cyc(4);
    total++;
    if (pend_o !== 8'h81) begin
      bad++; $display("FAIL level_capture pend_o=%h exp 81", pend_o);
    end
    do_ack(3'd7);
    total++;
    if (pend_o !== 8'h81) begin
      bad++; $display("FAIL level_set_wins pend_o=%h exp 81", pend_o);
    end
    req_in = 8'h01;
    cyc(4);
    total++;
    if (pend_o !== 8'h81) begin
      bad++; $display("FAIL level_sticky pend_o=%h exp 81", pend_o);
    end
    do_ack(3'd7);
    total++;
    if (pend_o !== 8'h01) begin
      bad++; $display("FAIL level_ack7 pend_o=%h exp 01", pend_o);
    end
    req_in = 8'h00;
    cyc(4);
    do_ack(3'd0);
    total++;
    if (pend_o !== 8'h00) begin
      bad++; $display("FAIL level_cleanup pend_o=%h exp 00", pend_o);
    end
  endtask

  task automatic test_mask();
    mode = 8'hFF; mask = 8'h0F;
    req_in = 8'h40;
    cyc(4);
    total++;
    if (pend_o !== 8'h00 || any_pend !== 1'b0) begin
      bad++; $display("FAIL mask_block pend_o=%h any=%b exp 00/0", pend_o, any_pend);
    end
    req_in = 8'h00;
    cyc(3);
    mask = 8'hFF;
    #1;
    total++;
    if (pend_o !== 8'h00) begin
      bad++; $display("FAIL mask_no_latent pend_o=%h exp 00", pend_o);
    end
    cyc(1);
    req_in = 8'h40;
    cyc(4);
    total++;
    if (pend_o !== 8'h40) begin
      bad++; $display("FAIL mask_capture pend_o=%h exp 40", pend_o);
    end
    mask = 8'h0F;
    #1;
    total++;
    if (pend_o !== 8'h00 || any_pend !== 1'b0) begin
      bad++; $display("FAIL mask_hide pend_o=%h any=%b exp 00/0", pend_o, any_pend);
    end
    cyc(2);
    mask = 8'hFF;
    #1;
    total++;
    if (pend_o !== 8'h40 || any_pend !== 1'b1) begin
      bad++; $display("FAIL mask_reappear pend_o=%h any=%b exp 40/1", pend_o, any_pend);
    end
    cyc(1);
    req_in = 8'h00;
    do_ack(3'd6);
    total++;
    if (pend_o !== 8'h00) begin
      bad++; $display("FAIL mask_cleanup pend_o=%h exp 00", pend_o);
    end
    cyc(3);
  endtask

  task automatic test_async_reset();
    mode = 8'hFF; mask = 8'hFF;
    req_in = 8'hA5;
    cyc(4);
    total++;
    if (pend_o !== 8'hA5) begin
      bad++; $display("FAIL areset_setup pend_o=%h exp a5", pend_o);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (pend_o !== 8'h00 || any_pend !== 1'b0) begin
      bad++; $display("FAIL areset_immediate pend_o=%h any=%b exp 00/0", pend_o, any_pend);
    end
    cyc(2);
    rst_n = 1'b1;               // lines still high: one edge event each
    cyc(4);
    total++;
    if (pend_o !== 8'hA5) begin
      bad++; $display("FAIL areset_rerelease pend_o=%h exp a5", pend_o);
    end
    req_in = 8'h00;
    do_ack(3'd7);
    do_ack(3'd5);
    do_ack(3'd2);
    do_ack(3'd0);
    total++;
    if (pend_o !== 8'h00) begin
      bad++; $display("FAIL areset_cleanup pend_o=%h exp 00", pend_o);
    end
    cyc(3);
  endtask

  task automatic test_double_edge();
    mode = 8'hFF; mask = 8'hFF;
    req_in = 8'h04;
    cyc(1);
    req_in = 8'h00;
    cyc(3);
    req_in = 8'h04;             // second rise, 4 cycles after the first
    cyc(1);
    req_in = 8'h00;
    cyc(4);
    total++;
    if (pend_o !== 8'h04) begin
      bad++; $display("FAIL dbl_pend pend_o=%h exp 04", pend_o);
    end
`ifdef IRQ_OVF_EN
    total++;
    if (ovf_o !== 8'h04) begin
      bad++; $display("FAIL dbl_ovf ovf_o=%h exp 04", ovf_o);
    end
`endif
    do_ack(3'd2);
    total++;
    if (pend_o !== 8'h00) begin
      bad++; $display("FAIL dbl_ack_pend pend_o=%h exp 00", pend_o);
    end
`ifdef IRQ_OVF_EN
    total++;
    if (ovf_o !== 8'h00) begin
      bad++; $display("FAIL dbl_ack_ovf ovf_o=%h exp 00", ovf_o);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_edge_capture();
    test_level_set_wins();
    test_mask();
    test_async_reset();
    test_double_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
